// File: rtl/fc_input_streamer.sv
// Streams a batch of input vectors from the 64-bit input BRAM to the FC layer,
// one sample per clock, waiting for the layer's out_valid between vectors.
module fc_input_streamer #(
    parameter int DIM_INPUT   = 96,
    parameter int INPUT_W     = 16,
    parameter int BRAM_DAT_W  = 64,
    parameter int BRAM_ADDR_W = 14,
    parameter int BATCH_NUM   = 320
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BRAM_ADDR_W-1:0] base_addr,
    output logic                   bram_en,
    output logic [BRAM_ADDR_W-1:0] bram_addr,
    input  logic [BRAM_DAT_W-1:0]  bram_dout,
    output logic [INPUT_W-1:0]     fc_in_dat,
    output logic                   fc_in_vld,
    input  logic                   fc_out_vld,
    output logic                   busy,
    output logic                   done,
    output logic [8:0]             vec_idx,
    output logic                   err
);

    localparam int LANES      = BRAM_DAT_W / INPUT_W;
    localparam int WPV        = DIM_INPUT / LANES;
    localparam int ISSUE_LANE = (LANES >= 2) ? LANES - 2 : 0;
    localparam int LANE_W     = $clog2(LANES + 1);
    localparam int RD_W       = $clog2(WPV + 1);
    localparam int EMIT_W     = $clog2(DIM_INPUT + 1);

    if (BRAM_DAT_W % INPUT_W != 0) begin : g_bad_lane
        $error("BRAM_DAT_W must be a multiple of INPUT_W");
    end
    if ((DIM_INPUT * INPUT_W) % BRAM_DAT_W != 0) begin : g_bad_vec
        $error("DIM_INPUT*INPUT_W must be a multiple of BRAM_DAT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [LANE_W-1:0]      lane;
    logic [RD_W-1:0]        rd_cnt;
    logic [EMIT_W-1:0]      emit_cnt;
    logic                   dat_vld;
    logic [BRAM_DAT_W-1:0]  word;
    logic [BRAM_ADDR_W-1:0] next_addr;

    logic                   start_acc;
    logic                   last_vec;
    logic                   vec_go;
    logic                   launch;
    logic                   stream_end;
    logic                   emit;
    logic                   issue;
    logic [LANE_W-1:0]      emit_lane;
    logic [BRAM_DAT_W-1:0]  src;
    logic [INPUT_W-1:0]     emit_sample;

    assign start_acc  = (state == S_IDLE) && start;
    assign last_vec   = (vec_idx == 9'(BATCH_NUM - 1));
    assign vec_go     = (state == S_WAIT) && fc_out_vld && !last_vec;
    assign launch     = start_acc || vec_go;
    assign stream_end = (state == S_STREAM) && (emit_cnt == EMIT_W'(DIM_INPUT));
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    // A fresh word arriving from the BRAM always supplies lane 0 directly,
    // so samples stay contiguous across word boundaries.
    always_comb begin
        emit        = 1'b0;
        emit_lane   = lane;
        src         = word;
        emit_sample = '0;
        issue       = 1'b0;
        if (state == S_STREAM) begin
            emit      = dat_vld || (lane < LANE_W'(LANES));
            emit_lane = dat_vld ? '0 : lane;
            src       = dat_vld ? bram_dout : word;
            issue     = emit && (emit_lane == LANE_W'(ISSUE_LANE)) && (rd_cnt < RD_W'(WPV));
        end
        emit_sample = INPUT_W'(src >> (INPUT_W * 32'(emit_lane)));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_STREAM;
            S_STREAM: if (stream_end) state_nxt = S_WAIT;
            S_WAIT:   if (fc_out_vld) state_nxt = last_vec ? S_DONE : S_STREAM;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en   <= 1'b0;
            bram_addr <= '0;
            next_addr <= '0;
            fc_in_dat <= '0;
            fc_in_vld <= 1'b0;
            vec_idx   <= '0;
            err       <= 1'b0;
            lane      <= LANE_W'(LANES);
            rd_cnt    <= '0;
            emit_cnt  <= '0;
            dat_vld   <= 1'b0;
            word      <= '0;
        end else begin
            dat_vld <= bram_en;

            if (launch) begin
                bram_en   <= 1'b1;
                bram_addr <= start_acc ? base_addr : next_addr;
                next_addr <= (start_acc ? base_addr : next_addr) + BRAM_ADDR_W'(1);
                vec_idx   <= start_acc ? 9'd0 : vec_idx + 9'd1;
                rd_cnt    <= RD_W'(1);
                emit_cnt  <= '0;
                lane      <= LANE_W'(LANES);
            end else if (issue) begin
                bram_en   <= 1'b1;
                bram_addr <= next_addr;
                next_addr <= next_addr + BRAM_ADDR_W'(1);
                rd_cnt    <= rd_cnt + RD_W'(1);
            end else begin
                bram_en <= 1'b0;
            end

            if (emit) begin
                fc_in_dat <= emit_sample;
                fc_in_vld <= 1'b1;
                emit_cnt  <= emit_cnt + EMIT_W'(1);
                lane      <= emit_lane + LANE_W'(1);
                if (dat_vld) word <= bram_dout;
            end else begin
                fc_in_vld <= 1'b0;
            end

            if (start_acc)
                err <= 1'b0;
            else if (fc_out_vld && (state != S_WAIT))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fc_input_streamer.sv
// Self-checking bench for fc_input_streamer: BRAM model plus a per-cycle monitor
// that predicts every read address and sample from base address and sample count.
module tb_fc_input_streamer;

    localparam int DIM   = 96;
    localparam int WPV   = 24;
    localparam int BATCH = 320;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] base_addr;
    logic        bram_en;
    logic [13:0] bram_addr;
    logic [63:0] bram_dout;
    logic [15:0] fc_in_dat;
    logic        fc_in_vld;
    logic        fc_out_vld;
    logic        busy;
    logic        done;
    logic [8:0]  vec_idx;
    logic        err;

    fc_input_streamer #(
        .DIM_INPUT  (DIM),
        .INPUT_W    (16),
        .BRAM_DAT_W (64),
        .BRAM_ADDR_W(14),
        .BATCH_NUM  (BATCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .fc_in_dat (fc_in_dat),
        .fc_in_vld (fc_in_vld),
        .fc_out_vld(fc_out_vld),
        .busy      (busy),
        .done      (done),
        .vec_idx   (vec_idx),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [0:16383];
    initial bram_dout = '0;
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

    typedef struct {
        logic [13:0] base;
        int          nvec;
        int          delay;
        bit          inj_start;
        bit          inj_ovld;
        int          exp_reads;
        logic [13:0] exp_last;
        bit          first_en;
        logic [15:0] exp_first;
    } row_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          launch_cyc = 0;
    int          n_smp = 0;
    int          rd_n = 0;
    int          n_done = 0;
    bit          prev_vld = 0;
    bit          exp_err = 0;
    logic [13:0] base_m = '0;
    logic [15:0] first_dat = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_sample(int n);
        logic [63:0] w;
        w = mem[14'(32'(base_m) + n / 4)];
        return w[16*(n%4) +: 16];
    endfunction

    // One clock: sample outputs on the falling edge and check them against the model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bram_en) begin
            chk("rd_addr", 32'(bram_addr), 32'(14'(32'(base_m) + rd_n)));
            if (rd_n % WPV == 0) chk("lat_rd", cyc - launch_cyc, 1);
            rd_n++;
        end
        if (fc_in_vld) begin
            if (n_smp == 0) first_dat = fc_in_dat;
            chk("sample", 32'(fc_in_dat), 32'(exp_sample(n_smp)));
            chk("vec_idx", 32'(vec_idx), n_smp / DIM);
            if (n_smp % DIM == 0) chk("lat_vec", cyc - launch_cyc, 3);
            else                  chk("contig", 32'(prev_vld), 1);
            n_smp++;
        end
        if (done) n_done++;
        prev_vld = fc_in_vld;
    endtask

    task automatic chk_reset();
        chk("rst_bram_en", 32'(bram_en), 0);
        chk("rst_bram_addr", 32'(bram_addr), 0);
        chk("rst_fc_in_dat", 32'(fc_in_dat), 0);
        chk("rst_fc_in_vld", 32'(fc_in_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_vec_idx", 32'(vec_idx), 0);
        chk("rst_err", 32'(err), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk_reset();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_start(logic [13:0] b);
        base_addr  = b;
        base_m     = b;
        n_smp      = 0;
        rd_n       = 0;
        n_done     = 0;
        exp_err    = 0;
        start      = 1'b1;
        launch_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_vec_end(int target);
        for (int i = 0; i < 200 && !(n_smp >= target && !fc_in_vld); i++) tick();
        chk("vec_end", n_smp, target);
    endtask

    task automatic stream_vec(int v, int delay, bit inj_start, bit inj_ovld);
        if (inj_start || inj_ovld) begin
            repeat (20) tick();
            if (inj_start) start = 1'b1;
            if (inj_ovld) begin
                fc_out_vld = 1'b1;
                exp_err    = 1'b1;
            end
            tick();
            start      = 1'b0;
            fc_out_vld = 1'b0;
        end
        wait_vec_end((v + 1) * DIM);
        chk("vec_idx_wait", 32'(vec_idx), v);
        if (inj_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("ign_start_busy", 32'(busy), 1);
            chk("ign_start_en", 32'(bram_en), 0);
            chk("ign_start_vec", 32'(vec_idx), v);
        end
        repeat (delay) tick();
        chk("err", 32'(err), 32'(exp_err));
        fc_out_vld = 1'b1;
        launch_cyc = cyc;
        tick();
        fc_out_vld = 1'b0;
    endtask

    task automatic run_row(row_t r);
        do_start(r.base);
        for (int v = 0; v < r.nvec - 1; v++) stream_vec(v, r.delay, r.inj_start, r.inj_ovld);
        wait_vec_end(r.nvec * DIM);
        chk("vec_idx_end", 32'(vec_idx), r.nvec - 1);
        chk("reads", rd_n, r.exp_reads);
        chk("last_addr", 32'(bram_addr), 32'(r.exp_last));
        chk("vld_in_wait", 32'(fc_in_vld), 0);
        chk("busy_in_wait", 32'(busy), 1);
        chk("err_end", 32'(err), 32'(exp_err));
        chk("no_done", n_done, 0);
        if (r.first_en) chk("first_smp", 32'(first_dat), 32'(r.exp_first));
        do_reset();
    endtask

    row_t rows [5];
    row_t r;
    logic [13:0] fb_base;

    initial begin
        rows[0] = '{14'h0010, 2, 5, 1'b0, 1'b0, 48, 14'h003F, 1'b1, 16'h0040};
        rows[1] = '{14'h3FF0, 1, 1, 1'b0, 1'b0, 24, 14'h0007, 1'b1, 16'hFFC0};
        rows[2] = '{14'h1234, 3, 0, 1'b1, 1'b0, 72, 14'h127B, 1'b1, 16'h48D0};
        rows[3] = '{14'h0100, 2, 3, 1'b0, 1'b1, 48, 14'h012F, 1'b1, 16'h0400};
        rows[4] = '{14'h3FE8, 2, 2, 1'b1, 1'b1, 48, 14'h0017, 1'b1, 16'hFFA0};

        for (int i = 0; i < 16384; i++)
            mem[i] = {16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)};

        rst        = 1'b1;
        start      = 1'b0;
        fc_out_vld = 1'b0;
        base_addr  = '0;
        tick();
        tick();
        chk_reset();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_row(rows[i]);

        // err set in IDLE, cleared by the next accepted start
        fc_out_vld = 1'b1;
        tick();
        fc_out_vld = 1'b0;
        chk("err_idle", 32'(err), 1);
        chk("busy_idle", 32'(busy), 0);
        do_start(14'h0020);
        chk("err_cleared", 32'(err), 0);
        chk("busy_rise", 32'(busy), 1);
        do_reset();

        for (int i = 0; i < 16384; i++) mem[i] = {$urandom, $urandom};

        for (int k = 0; k < 6; k++) begin
            r.base      = 14'($urandom);
            r.nvec      = int'($urandom_range(1, 3));
            r.delay     = int'($urandom_range(0, 6));
            r.inj_start = 1'($urandom);
            r.inj_ovld  = 1'($urandom);
            r.exp_reads = r.nvec * WPV;
            r.exp_last  = 14'(32'(r.base) + r.nvec * WPV - 1);
            r.first_en  = 1'b0;
            r.exp_first = '0;
            run_row(r);
        end

        // reset at sample 50 of vector 3, then replay from vector 0
        do_start(14'h0200);
        for (int v = 0; v < 3; v++) stream_vec(v, 0, 1'b0, 1'b0);
        for (int i = 0; i < 200 && n_smp < 3*DIM + 51; i++) tick();
        chk("rst_point", n_smp, 3*DIM + 51);
        rst = 1'b1;
        tick();
        chk_reset();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_rd_after_rst", 32'(bram_en), 0);
            chk("no_vld_after_rst", 32'(fc_in_vld), 0);
        end
        do_start(14'h0200);
        wait_vec_end(DIM);
        chk("replay_vec", 32'(vec_idx), 0);
        do_reset();

        // full default batch, out_valid returned one cycle after each vector
        fb_base = 14'($urandom);
        do_start(fb_base);
        for (int v = 0; v < BATCH - 1; v++) stream_vec(v, 1, 1'b0, 1'b0);
        wait_vec_end(BATCH * DIM);
        chk("last_vec_idx", 32'(vec_idx), BATCH - 1);
        tick();
        fc_out_vld = 1'b1;
        tick();
        fc_out_vld = 1'b0;
        chk("done_pulse", 32'(done), 1);
        chk("busy_in_done", 32'(busy), 1);
        tick();
        chk("busy_after_done", 32'(busy), 0);
        chk("done_low", 32'(done), 0);
        chk("done_count", n_done, 1);
        chk("batch_samples", n_smp, BATCH * DIM);
        chk("batch_reads", rd_n, BATCH * WPV);
        chk("batch_last_addr", 32'(bram_addr), 32'(14'(32'(fb_base) + BATCH*WPV - 1)));
        chk("batch_err", 32'(err), 0);
        repeat (5) tick();
        chk("idle_no_rd", 32'(bram_en), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fc_input_streamer.md
# fc_input_streamer

Upstream feeder for the FC layer: on a start pulse, reads a batch of input vectors from the shared 64-bit input BRAM (filled over PCIe by the host) and streams them to the FC layer one 16-bit sample per clock. Each BRAM word is unpacked into `BRAM_DAT_W/INPUT_W` samples with no bubbles. After each vector the block waits for the layer's `out_valid` before sending the next vector. It pulses `done` after `BATCH_NUM` vectors. It sits between the BRAM read port and `FC_Layer.in_dat/in_valid`, under control of the FC control FSM.

## Interface
Parameters:
- `DIM_INPUT`, 96: samples per vector.
- `INPUT_W`, 16: sample width.
- `BRAM_DAT_W`, 64: BRAM word width. Must be a multiple of `INPUT_W`; `DIM_INPUT*INPUT_W` must be a multiple of `BRAM_DAT_W`. Either violation is an elaboration error.
- `BRAM_ADDR_W`, 14: BRAM word-address width.
- `BATCH_NUM`, 320: vectors per batch.
- Derived: `LANES = BRAM_DAT_W/INPUT_W` (4); `WPV = DIM_INPUT/LANES` (24 words per vector).

Ports:
- `clk`  in  1  the only clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse. Accepted only in IDLE.
- `base_addr`  in  `BRAM_ADDR_W`  word address of vector 0. Sampled with an accepted `start`.
- `bram_en`  out  1  read enable. Read latency is fixed at 1 cycle.
- `bram_addr`  out  `BRAM_ADDR_W`  read word address.
- `bram_dout`  in  `BRAM_DAT_W`  read data, valid the cycle after `bram_en`.
- `fc_in_dat`  out  `INPUT_W`  sample to FC layer. Raw bits, no conversion.
- `fc_in_vld`  out  1  sample valid.
- `fc_out_vld`  in  1  FC layer output valid; marks the vector as consumed.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse at batch end.
- `vec_idx`  out  9  index of the vector currently being streamed or awaited.
- `err`  out  1  sticky: `fc_out_vld` seen outside WAIT. Cleared by `rst` or by an accepted `start`.

## Operation
- States: IDLE, STREAM, WAIT, DONE.
- IDLE, with `start`=1: latch `base_addr` into the read-address counter, clear `vec_idx` and `err`, go to STREAM. `start` in any other state is ignored.
- STREAM: reads `WPV` consecutive words and emits `DIM_INPUT` samples.
  - Lane order is LSB first: lane 0 = `dout[INPUT_W-1:0]`.
  - The word register captures `bram_dout` in the cycle after each read.
  - The next read is issued in the cycle lane `LANES-2` of the current word is emitted, so samples are contiguous.
  - After the last lane of word `WPV-1`, go to WAIT. No extra read is issued.
- Read address is `base + v*WPV + w` and increments by 1 per read across vectors. It wraps modulo 2^`BRAM_ADDR_W` without error.
- WAIT, on `fc_out_vld`=1:
  - If `vec_idx` = `BATCH_NUM-1`, go to DONE.
  - Otherwise increment `vec_idx` and go to STREAM.
- DONE: `done`=1 for one cycle, then IDLE.
- `fc_out_vld` in IDLE, STREAM or DONE: no state effect; sets `err`.
- Reset values: state IDLE; `bram_en`, `fc_in_vld`, `busy`, `done`, `err` = 0; `bram_addr`, `fc_in_dat`, `vec_idx` = 0.
- Reset mid-batch: all outputs return to reset values on the next edge and no further reads are issued. A late `bram_dout` is discarded.

## Timing
- `start` high in cycle S:
  - `bram_en`=1 with `bram_addr`=base in S+1.
  - First `fc_in_vld` in S+3.
  - 96 contiguous valid samples in S+3..S+98.
- Word k of a vector is read in S+1+4k (default parameters). Sample j is output in S+3+j.
- `fc_in_vld` is low in WAIT, DONE and IDLE. `fc_in_dat` holds its last value when invalid.
- `fc_out_vld` in cycle W (during WAIT): the next vector's read is issued in W+1 and its first sample is output in W+3.
- `fc_out_vld` on the final vector in cycle W: `done`=1 in W+1 and `busy`=0 from W+2.
- `busy` rises in S+1.

## Test plan
- Single batch, `BATCH_NUM`=2, base=0x0010, BRAM word n = {16'(4n+3), 16'(4n+2), 16'(4n+1), 16'(4n)}. Stimulus: `fc_out_vld` pulsed 5 cycles after the last sample. Required: samples 0x0040..0x009F for vector 0, then 0x00A0..0x00FF for vector 1, each 96-cycle run contiguous, `done` once, 48 reads total.
- Address wrap: base=0x3FF0, `BATCH_NUM`=1. Required: `bram_addr` sequence 0x3FF0..0x3FFF, 0x0000..0x0007.
- `start` during STREAM and during WAIT. Required: ignored; sample stream and `vec_idx` unchanged.
- `fc_out_vld` pulsed during STREAM. Required: `err`=1, streaming continues unchanged. The next `start` clears `err`.
- `rst` asserted at sample 50 of vector 3. Required: all outputs at reset values next cycle, no `bram_en` afterwards. A fresh `start` replays the batch from vector 0.
- Full default batch (320 vectors), with `fc_out_vld` returned one cycle after each vector. Required: 30720 samples, final read address base+7679, `done` exactly once.
